mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the pipelined RISC core. Sits directly downstream of the EX-to-MEM pipeline register.
- Performs load/store accesses on a req/ack data-memory port and stalls the upstream stages while an access is outstanding.
- Contains the MEM-to-WB pipeline register that feeds writeback.

Parameters:
- DATA_W, 16, width of data, ALU result, instruction and memory words
- TO_CYC, 16, max cycles in REQ without Dmem_Ack before abort (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- Valid_In  in  1  EX/MEM holds a real instruction (0 = bubble)
- Ctrl_In  in  3  {Rd_Wr_En, Mem_Rd_En, Mem_Wr_En} from EX/MEM
- Rd_Addr_In  in  3  destination register
- Rd_Data_In  in  DATA_W  non-load writeback data
- ALU_Result_In  in  DATA_W  memory address
- RF_D2_In  in  DATA_W  store data
- Instr_In  in  DATA_W  instruction word
- Dmem_Req  out  1  access request
- Dmem_We  out  1  1 = write
- Dmem_Addr  out  DATA_W  address
- Dmem_Wdata  out  DATA_W  write data
- Dmem_Rdata  in  DATA_W  read data, valid with Dmem_Ack
- Dmem_Ack  in  1  access complete
- Stall_Out  out  1  freeze PC/IF/ID/EX and all upstream pipeline registers
- Fwd_Valid  out  1  forwarding data valid this cycle
- Fwd_Rd_Addr  out  3  forwarding destination register
- Fwd_Rd_Data  out  DATA_W  forwarding data
- WB_Valid  out  1  MEM/WB holds a real instruction
- WB_Rd_Wr_En  out  1  register-file write enable for WB
- WB_Rd_Addr  out  3  writeback destination register
- WB_Rd_Data  out  DATA_W  writeback data
- WB_Instr  out  DATA_W  instruction word in WB
- Mem_Err  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state): FSM = IDLE, timeout counter = 0. All WB_* outputs, Dmem_Req, Dmem_We and Mem_Err go to 0 immediately. A reset during REQ drops Dmem_Req in the same cycle with no handshake completion.
- Access condition: acc = Valid_In & (Mem_Rd_En | Mem_Wr_En). If both Mem_Rd_En and Mem_Wr_En are set, treat as a write.
- FSM IDLE:
  - acc=0: MEM/WB loads on each posedge. WB_Valid = Valid_In, WB_Rd_Wr_En = Valid_In & Rd_Wr_En, WB_Rd_Data = Rd_Data_In. Stall_Out = 0.
  - acc=1: Stall_Out = 1 (combinational). MEM/WB loads a bubble (WB_Valid = 0, WB_Rd_Wr_En = 0, other WB fields hold). Next state REQ. On entry, latch address, write data and write flag into internal regs.
- FSM REQ: Dmem_Req = 1 (registered), with Dmem_We/Dmem_Addr/Dmem_Wdata from the latched regs, held stable until ack.
  - Dmem_Ack=0: Stall_Out = 1, counter increments.
  - Dmem_Ack=1: Stall_Out = 0. MEM/WB loads the instruction with WB_Valid = 1, WB_Rd_Wr_En = Rd_Wr_En & ~Mem_Wr_En. WB_Rd_Data = Dmem_Rdata for loads, else Rd_Data_In. Dmem_Req deasserts next cycle. Counter clears. Next state IDLE.
  - Ack may arrive in the first REQ cycle, giving minimum memory-op latency 2 cycles (EX/MEM presentation to WB load) and 1 stall cycle.
  - Ack and counter reaching TO_CYC-1 in the same cycle: ack wins.
  - Counter reaches TO_CYC-1 without ack: set Mem_Err (sticky until reset), drop Dmem_Req, load a bubble into MEM/WB, Stall_Out = 0 that cycle, return to IDLE. The instruction is discarded.
- Dmem_Ack while in IDLE: ignored.
- Non-memory instructions: 1-cycle latency, no stall. Back-to-back memory ops re-enter REQ via one IDLE cycle each.
- Forwarding (combinational):
  - Fwd_Valid = Valid_In & Rd_Wr_En & ~(Mem_Rd_En & ~(REQ & Dmem_Ack)).
  - Fwd_Rd_Data = Dmem_Rdata when a load acks, else Rd_Data_In.
  - Fwd_Rd_Addr = Rd_Addr_In.
- WB_Instr and WB_Rd_Addr load together with WB_Valid=1 updates. When a bubble loads they hold their previous values.

Test Plan:
- Reset: drive rst high during REQ with Dmem_Req=1 -> Dmem_Req, WB_Valid, Mem_Err all 0 before the next clk edge; FSM IDLE.
- ALU op: Valid_In=1, Ctrl=100, Rd_Addr=3, Rd_Data=16'h1234 -> after one posedge WB_Valid=1, WB_Rd_Wr_En=1, WB_Rd_Addr=3, WB_Rd_Data=16'h1234; Stall_Out never 1.
- Load, 0-wait: Ctrl=110, ALU_Result=16'h0040, memory acks in first REQ cycle with 16'hBEEF -> Dmem_Addr=16'h0040, Dmem_We=0, exactly 1 stall cycle, WB_Rd_Data=16'hBEEF.
- Store, 3-wait: Ctrl=001, addr 16'h0010, RF_D2=16'hA5A5, ack on 4th REQ cycle -> Dmem_We=1, Dmem_Wdata=16'hA5A5 stable for 4 cycles, Stall_Out high 4 cycles, WB_Rd_Wr_En=0, WB_Valid=1.
- Timeout: load with no ack, TO_CYC=16 -> Mem_Err=1 after 16 REQ cycles, Dmem_Req drops, WB_Valid=0, Stall_Out released. A following ALU op completes normally with Mem_Err still 1.
- Back-to-back: load r2 (ack 0-wait), store, ALU op -> WB sequence valid,valid,valid with correct data; stray Dmem_Ack during the ALU op causes no change.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory stage of the pipelined core: drives the req/ack data-memory port,
// stalls upstream while an access is outstanding, and holds the MEM/WB register.
module mem_access_stage #(
    parameter int DATA_W = 16,
    parameter int TO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid_In,
    input  logic [2:0]        Ctrl_In,
    input  logic [2:0]        Rd_Addr_In,
    input  logic [DATA_W-1:0] Rd_Data_In,
    input  logic [DATA_W-1:0] ALU_Result_In,
    input  logic [DATA_W-1:0] RF_D2_In,
    input  logic [DATA_W-1:0] Instr_In,
    output logic              Dmem_Req,
    output logic              Dmem_We,
    output logic [DATA_W-1:0] Dmem_Addr,
    output logic [DATA_W-1:0] Dmem_Wdata,
    input  logic [DATA_W-1:0] Dmem_Rdata,
    input  logic              Dmem_Ack,
    output logic              Stall_Out,
    output logic              Fwd_Valid,
    output logic [2:0]        Fwd_Rd_Addr,
    output logic [DATA_W-1:0] Fwd_Rd_Data,
    output logic              WB_Valid,
    output logic              WB_Rd_Wr_En,
    output logic [2:0]        WB_Rd_Addr,
    output logic [DATA_W-1:0] WB_Rd_Data,
    output logic [DATA_W-1:0] WB_Instr,
    output logic              Mem_Err
);
    localparam int CNT_W = $clog2(TO_CYC);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] addr_reg, wdata_reg;
    logic              we_reg;
    logic              err_reg;
    logic              wb_valid_reg, wb_wr_en_reg;
    logic [2:0]        wb_addr_reg;
    logic [DATA_W-1:0] wb_data_reg, wb_instr_reg;

    logic rd_wr_en, mem_rd, mem_wr, acc, is_load;
    logic in_req, ack_hit, timeout;
    logic stall, ld_pass, ld_bubble, ld_mem, set_err;

    assign rd_wr_en = Ctrl_In[2];
    assign mem_rd   = Ctrl_In[1];
    assign mem_wr   = Ctrl_In[0];
    // Read+write together behaves as a store, so only a pure read is a load.
    assign acc      = Valid_In & (mem_rd | mem_wr);
    assign is_load  = mem_rd & ~mem_wr;
    assign in_req   = (state_reg == REQ);
    assign ack_hit  = in_req & Dmem_Ack;
    assign timeout  = in_req & ~Dmem_Ack & (cnt_reg == CNT_W'(TO_CYC - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        ld_pass    = 1'b0;
        ld_bubble  = 1'b0;
        ld_mem     = 1'b0;
        set_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (acc) begin
                    stall      = 1'b1;
                    ld_bubble  = 1'b1;
                    state_next = REQ;
                end else begin
                    ld_pass = 1'b1;
                end
            end
            REQ: begin
                if (Dmem_Ack) begin
                    ld_mem     = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (timeout) begin
                    // Give up: drop the instruction and let the pipeline run on.
                    ld_bubble  = 1'b1;
                    set_err    = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    stall    = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            err_reg      <= 1'b0;
            wb_valid_reg <= 1'b0;
            wb_wr_en_reg <= 1'b0;
            wb_addr_reg  <= '0;
            wb_data_reg  <= '0;
            wb_instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (set_err)
                err_reg <= 1'b1;
            if (state_reg == IDLE && acc) begin
                addr_reg  <= ALU_Result_In;
                wdata_reg <= RF_D2_In;
                we_reg    <= mem_wr;
            end
            if (ld_pass) begin
                wb_valid_reg <= Valid_In;
                wb_wr_en_reg <= Valid_In & rd_wr_en;
                wb_data_reg  <= Rd_Data_In;
                if (Valid_In) begin
                    wb_addr_reg  <= Rd_Addr_In;
                    wb_instr_reg <= Instr_In;
                end
            end
            if (ld_bubble) begin
                wb_valid_reg <= 1'b0;
                wb_wr_en_reg <= 1'b0;
            end
            if (ld_mem) begin
                wb_valid_reg <= 1'b1;
                wb_wr_en_reg <= rd_wr_en & ~mem_wr;
                wb_data_reg  <= is_load ? Dmem_Rdata : Rd_Data_In;
                wb_addr_reg  <= Rd_Addr_In;
                wb_instr_reg <= Instr_In;
            end
        end
    end

    assign Dmem_Req    = in_req;
    assign Dmem_We     = in_req & we_reg;
    assign Dmem_Addr   = addr_reg;
    assign Dmem_Wdata  = wdata_reg;
    assign Stall_Out   = stall;
    // A load only has forwardable data in the cycle its ack arrives.
    assign Fwd_Valid   = Valid_In & rd_wr_en & ~(mem_rd & ~ack_hit);
    assign Fwd_Rd_Addr = Rd_Addr_In;
    assign Fwd_Rd_Data = (ack_hit & is_load) ? Dmem_Rdata : Rd_Data_In;
    assign WB_Valid    = wb_valid_reg;
    assign WB_Rd_Wr_En = wb_wr_en_reg;
    assign WB_Rd_Addr  = wb_addr_reg;
    assign WB_Rd_Data  = wb_data_reg;
    assign WB_Instr    = wb_instr_reg;
    assign Mem_Err     = err_reg;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU ops, loads/stores with varying wait
// states, timeout abort, back-to-back ops and asynchronous reset mid-access.
module tb_mem_access_stage;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          Valid_In;
    logic [2:0]    Ctrl_In;
    logic [2:0]    Rd_Addr_In;
    logic [DW-1:0] Rd_Data_In, ALU_Result_In, RF_D2_In, Instr_In;
    logic          Dmem_Req, Dmem_We;
    logic [DW-1:0] Dmem_Addr, Dmem_Wdata, Dmem_Rdata;
    logic          Dmem_Ack;
    logic          Stall_Out, Fwd_Valid;
    logic [2:0]    Fwd_Rd_Addr;
    logic [DW-1:0] Fwd_Rd_Data;
    logic          WB_Valid, WB_Rd_Wr_En;
    logic [2:0]    WB_Rd_Addr;
    logic [DW-1:0] WB_Rd_Data, WB_Instr;
    logic          Mem_Err;

    int n_checks = 0;
    int n_pass   = 0;
    int stalls, reqs;

    mem_access_stage #(.DATA_W(DW), .TO_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .Valid_In(Valid_In), .Ctrl_In(Ctrl_In), .Rd_Addr_In(Rd_Addr_In),
        .Rd_Data_In(Rd_Data_In), .ALU_Result_In(ALU_Result_In),
        .RF_D2_In(RF_D2_In), .Instr_In(Instr_In),
        .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We), .Dmem_Addr(Dmem_Addr),
        .Dmem_Wdata(Dmem_Wdata), .Dmem_Rdata(Dmem_Rdata), .Dmem_Ack(Dmem_Ack),
        .Stall_Out(Stall_Out), .Fwd_Valid(Fwd_Valid), .Fwd_Rd_Addr(Fwd_Rd_Addr),
        .Fwd_Rd_Data(Fwd_Rd_Data), .WB_Valid(WB_Valid), .WB_Rd_Wr_En(WB_Rd_Wr_En),
        .WB_Rd_Addr(WB_Rd_Addr), .WB_Rd_Data(WB_Rd_Data), .WB_Instr(WB_Instr),
        .Mem_Err(Mem_Err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [2:0] ctrl, input logic [2:0] rd, input logic [DW-1:0] rdata,
                             input logic [DW-1:0] alu, input logic [DW-1:0] d2, input logic [DW-1:0] ins);
        Valid_In      = 1'b1;
        Ctrl_In       = ctrl;
        Rd_Addr_In    = rd;
        Rd_Data_In    = rdata;
        ALU_Result_In = alu;
        RF_D2_In      = d2;
        Instr_In      = ins;
    endtask

    // Runs a memory op already presented on the inputs (stage in IDLE).
    // ack_on = REQ cycle (1-based) in which memory acks; 0 = never.
    task automatic mem_op(input int ack_on, input logic [DW-1:0] rdata, input logic [DW-1:0] exp_addr,
                          input logic [DW-1:0] exp_wdata, input logic exp_we,
                          output int n_stall, output int n_req);
        logic done;
        done    = 1'b0;
        n_stall = 0;
        n_req   = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (Dmem_Req) begin
                n_req++;
                check("dmem_addr", Dmem_Addr, exp_addr);
                check("dmem_we", Dmem_We, exp_we);
                if (exp_we) check("dmem_wdata", Dmem_Wdata, exp_wdata);
                if (n_req == ack_on) begin
                    Dmem_Ack   = 1'b1;
                    Dmem_Rdata = rdata;
                end
            end
            #1;
            if (Stall_Out) n_stall++;
            done = Dmem_Req && (Dmem_Ack || !Stall_Out);
            tick();
            Dmem_Ack = 1'b0;
        end
        check("mem_op_done", done, 1'b1);
        Valid_In = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        Valid_In = 1'b0; Ctrl_In = '0; Rd_Addr_In = '0; Rd_Data_In = '0;
        ALU_Result_In = '0; RF_D2_In = '0; Instr_In = '0;
        Dmem_Ack = 1'b0; Dmem_Rdata = '0;
        tick(); tick();
        check("rst_wb_valid", WB_Valid, 1'b0);
        check("rst_req", Dmem_Req, 1'b0);
        check("rst_we", Dmem_We, 1'b0);
        check("rst_err", Mem_Err, 1'b0);
        rst = 1'b0;
        tick();

        // ALU op
        set_instr(3'b100, 3'd3, 16'h1234, 16'h0, 16'h0, 16'h0111);
        #1;
        check("alu_stall", Stall_Out, 1'b0);
        check("alu_fwd_valid", Fwd_Valid, 1'b1);
        check("alu_fwd_data", Fwd_Rd_Data, 16'h1234);
        check("alu_fwd_addr", Fwd_Rd_Addr, 3'd3);
        tick();
        Valid_In = 1'b0;
        check("alu_wb_valid", WB_Valid, 1'b1);
        check("alu_wb_wren", WB_Rd_Wr_En, 1'b1);
        check("alu_wb_addr", WB_Rd_Addr, 3'd3);
        check("alu_wb_data", WB_Rd_Data, 16'h1234);
        check("alu_wb_instr", WB_Instr, 16'h0111);
        $display("txn alu: wb_data=%h", WB_Rd_Data);

        // Load with 0 wait states
        set_instr(3'b110, 3'd2, 16'h5555, 16'h0040, 16'h0, 16'h0222);
        #1;
        check("ld_fwd_valid_idle", Fwd_Valid, 1'b0);
        mem_op(1, 16'hBEEF, 16'h0040, 16'h0, 1'b0, stalls, reqs);
        check("ld_stalls", stalls, 1);
        check("ld_reqs", reqs, 1);
        check("ld_wb_valid", WB_Valid, 1'b1);
        check("ld_wb_wren", WB_Rd_Wr_En, 1'b1);
        check("ld_wb_data", WB_Rd_Data, 16'hBEEF);
        check("ld_wb_addr", WB_Rd_Addr, 3'd2);
        check("ld_req_drop", Dmem_Req, 1'b0);
        $display("txn load0: stalls=%0d wb_data=%h", stalls, WB_Rd_Data);

        // Store with 3 wait states
        set_instr(3'b001, 3'd5, 16'h7777, 16'h0010, 16'hA5A5, 16'h0333);
        mem_op(4, 16'hDEAD, 16'h0010, 16'hA5A5, 1'b1, stalls, reqs);
        check("st_stalls", stalls, 4);
        check("st_reqs", reqs, 4);
        check("st_wb_valid", WB_Valid, 1'b1);
        check("st_wb_wren", WB_Rd_Wr_En, 1'b0);
        check("st_wb_instr", WB_Instr, 16'h0333);
        check("st_wb_data", WB_Rd_Data, 16'h7777);
        $display("txn store3: stalls=%0d reqs=%0d", stalls, reqs);

        // Timeout: load that is never acked
        set_instr(3'b110, 3'd6, 16'h0, 16'h0080, 16'h0, 16'h0444);
        mem_op(0, 16'h0, 16'h0080, 16'h0, 1'b0, stalls, reqs);
        check("to_stalls", stalls, 16);
        check("to_reqs", reqs, 16);
        check("to_err", Mem_Err, 1'b1);
        check("to_req_drop", Dmem_Req, 1'b0);
        check("to_wb_valid", WB_Valid, 1'b0);
        check("to_wb_instr_hold", WB_Instr, 16'h0333);
        $display("txn timeout: reqs=%0d err=%b", reqs, Mem_Err);
        set_instr(3'b100, 3'd1, 16'h0ABC, 16'h0, 16'h0, 16'h0555);
        #1;
        check("to_alu_stall", Stall_Out, 1'b0);
        tick();
        Valid_In = 1'b0;
        check("to_alu_wb_valid", WB_Valid, 1'b1);
        check("to_alu_wb_data", WB_Rd_Data, 16'h0ABC);
        check("to_alu_err_sticky", Mem_Err, 1'b1);
        $display("txn alu_after_timeout: wb_data=%h", WB_Rd_Data);

        // Back-to-back: load r2, store, ALU op with stray ack
        set_instr(3'b110, 3'd2, 16'h0, 16'h0050, 16'h0, 16'h0666);
        mem_op(1, 16'h1357, 16'h0050, 16'h0, 1'b0, stalls, reqs);
        check("b2b_ld_valid", WB_Valid, 1'b1);
        check("b2b_ld_data", WB_Rd_Data, 16'h1357);
        $display("txn b2b_load: wb_data=%h", WB_Rd_Data);
        set_instr(3'b001, 3'd0, 16'h0999, 16'h0020, 16'h2468, 16'h0777);
        mem_op(1, 16'h0, 16'h0020, 16'h2468, 1'b1, stalls, reqs);
        check("b2b_st_valid", WB_Valid, 1'b1);
        check("b2b_st_wren", WB_Rd_Wr_En, 1'b0);
        check("b2b_st_instr", WB_Instr, 16'h0777);
        $display("txn b2b_store: stalls=%0d", stalls);
        set_instr(3'b100, 3'd4, 16'h1111, 16'h0, 16'h0, 16'h0888);
        Dmem_Ack = 1'b1;
        Dmem_Rdata = 16'hFFFF;
        #1;
        check("stray_stall", Stall_Out, 1'b0);
        check("stray_fwd_data", Fwd_Rd_Data, 16'h1111);
        tick();
        Dmem_Ack = 1'b0;
        Valid_In = 1'b0;
        check("stray_req", Dmem_Req, 1'b0);
        check("stray_wb_valid", WB_Valid, 1'b1);
        check("stray_wb_data", WB_Rd_Data, 16'h1111);
        check("stray_wb_addr", WB_Rd_Addr, 3'd4);
        tick();
        check("bubble_wb_valid", WB_Valid, 1'b0);
        $display("txn b2b_alu: wb_data=%h", WB_Rd_Data);

        // Asynchronous reset in the middle of a REQ
        set_instr(3'b110, 3'd7, 16'h0, 16'h0090, 16'h0, 16'h0999);
        tick();
        check("ar_req_before", Dmem_Req, 1'b1);
        rst = 1'b1;
        #1;
        check("ar_req", Dmem_Req, 1'b0);
        check("ar_wb_valid", WB_Valid, 1'b0);
        check("ar_err", Mem_Err, 1'b0);
        Valid_In = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        check("ar_idle_stall", Stall_Out, 1'b0);
        check("ar_idle_req", Dmem_Req, 1'b0);
        $display("txn async_reset: req=%b err=%b", Dmem_Req, Mem_Err);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
